// File: rtl/spi_flash_arbiter_if.sv
// Requester, engine and flash-select signals shared by the SPI flash arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface spi_flash_arbiter_if;
  logic       boot_done;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [7:0] m0_tx_byte;
  logic       m0_tx_dv;
  logic [7:0] m1_tx_byte;
  logic       m1_tx_dv;
  logic [1:0] m_tx_ready;
  logic [7:0] rx_byte;
  logic [1:0] rx_dv;
  logic [7:0] eng_tx_byte;
  logic       eng_tx_dv;
  logic       eng_tx_ready;
  logic       eng_rx_dv;
  logic [7:0] eng_rx_byte;
  logic       spi_cs_n;
  logic       timeout_err;

  modport slave (
    input  boot_done, req, m0_tx_byte, m0_tx_dv, m1_tx_byte, m1_tx_dv,
           eng_tx_ready, eng_rx_dv, eng_rx_byte,
    output gnt, m_tx_ready, rx_byte, rx_dv, eng_tx_byte, eng_tx_dv,
           spi_cs_n, timeout_err
  );

  modport master (
    output boot_done, req, m0_tx_byte, m0_tx_dv, m1_tx_byte, m1_tx_dv,
           eng_tx_ready, eng_rx_dv, eng_rx_byte,
    input  gnt, m_tx_ready, rx_byte, rx_dv, eng_tx_byte, eng_tx_dv,
           spi_cs_n, timeout_err
  );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Grants whole SPI flash transactions to the boot loader (0) or runtime client (1),
// enforcing CS setup, minimum deselect time and a stall timeout on the owner.
module spi_flash_arbiter #(
    parameter int unsigned CS_SETUP_CYCLES = 2,
    parameter int unsigned CS_HOLD_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 16'hFFFF
) (
    input logic                  clk,
    input logic                  rst_n,
    spi_flash_arbiter_if.slave   bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_OWN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;

    localparam logic [7:0]  SETUP_LOAD = 8'(CS_SETUP_CYCLES - 1);
    localparam logic [7:0]  HOLD_LOAD  = 8'(CS_HOLD_CYCLES - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);
    localparam bit          TO_EN      = (TIMEOUT_CYCLES != 0);

    logic [2:0]  state;
    logic        owner;
    logic        last_owner;
    logic [1:0]  blocked;
    logic [1:0]  gnt_q;
    logic [7:0]  cnt;
    logic [15:0] to_cnt;
    logic        cs_n_q;
    logic        timeout_q;

    logic [1:0] eligible;
    logic       win_valid;
    logic       winner;
    logic       owner_req;
    logic       owner_dv;
    logic [7:0] owner_byte;
    logic       in_own;
    logic       launch;
    logic       timeout_hit;
    logic       go_hold;
    logic [1:0] owner_mask;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        eligible  = bus.req & ~blocked;
        win_valid = |eligible;
        winner    = 1'b0;
        if (!bus.boot_done)
            winner = ~eligible[0];
        else if (&eligible)
            winner = ~last_owner;
        else
            winner = eligible[1];
    end

    assign owner_req   = bus.req[owner];
    assign owner_dv    = owner ? bus.m1_tx_dv   : bus.m0_tx_dv;
    assign owner_byte  = owner ? bus.m1_tx_byte : bus.m0_tx_byte;
    assign owner_mask  = owner ? 2'b10 : 2'b01;
    assign in_own      = (state == ST_OWN);
    assign launch      = in_own && owner_dv && owner_req && bus.eng_tx_ready;

    // The counter only advances while the engine is idle, so a long shift never aborts.
    assign timeout_hit = TO_EN && in_own && owner_req && !launch &&
                         bus.eng_tx_ready && (to_cnt == TO_LAST);

    assign go_hold = ((state == ST_SETUP) && !owner_req) ||
                     (in_own && !owner_req && bus.eng_tx_ready) ||
                     ((state == ST_DRAIN) && bus.eng_tx_ready);

    assign bus.eng_tx_dv   = launch;
    assign bus.eng_tx_byte = in_own ? owner_byte : 8'h00;
    assign bus.rx_byte     = bus.eng_rx_byte;
    assign bus.rx_dv       = ((in_own || state == ST_DRAIN) && bus.eng_rx_dv) ? owner_mask : 2'b00;
    assign bus.gnt         = gnt_q;
    assign bus.m_tx_ready  = gnt_q & {2{bus.eng_tx_ready}};
    assign bus.spi_cs_n    = cs_n_q;
    assign bus.timeout_err = timeout_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            blocked    <= 2'b00;
            gnt_q      <= 2'b00;
            cnt        <= 8'h00;
            to_cnt     <= 16'h0000;
            cs_n_q     <= 1'b1;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            // An aborted requester stays locked out until it releases req.
            blocked   <= (blocked & bus.req) | (timeout_hit ? owner_mask : 2'b00);

            if (go_hold) begin
                state      <= ST_HOLD;
                gnt_q      <= 2'b00;
                cs_n_q     <= 1'b1;
                last_owner <= owner;
                cnt        <= HOLD_LOAD;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (win_valid) begin
                            owner  <= winner;
                            cs_n_q <= 1'b0;
                            cnt    <= SETUP_LOAD;
                            state  <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        if (cnt == 8'h00) begin
                            gnt_q  <= owner_mask;
                            to_cnt <= 16'h0000;
                            state  <= ST_OWN;
                        end else begin
                            cnt <= cnt - 8'h01;
                        end
                    end
                    ST_OWN: begin
                        if (!owner_req) begin
                            gnt_q <= 2'b00;
                            state <= ST_DRAIN;
                        end else if (timeout_hit) begin
                            gnt_q <= 2'b00;
                            state <= ST_DRAIN;
                        end else if (launch) begin
                            to_cnt <= 16'h0000;
                        end else if (bus.eng_tx_ready) begin
                            to_cnt <= to_cnt + 16'h0001;
                        end
                    end
                    ST_DRAIN: ;
                    ST_HOLD: begin
                        if (cnt == 8'h00)
                            state <= ST_IDLE;
                        else
                            cnt <= cnt - 8'h01;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter: a per-cycle vector table for one full
// transaction, plus hand-written sequences for priority, round-robin, timeout and reset.
module tb_spi_flash_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    spi_flash_arbiter_if bus();

    spi_flash_arbiter #(
        .CS_SETUP_CYCLES(2),
        .CS_HOLD_CYCLES (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        logic [7:0] m0_b;
        logic       m0_dv;
        logic       m1_dv;
        logic       rx_in;
        logic [1:0] e_gnt;
        logic       e_cs_n;
        logic       e_tx_dv;
        logic [7:0] e_tx_b;
        logic [1:0] e_rx_dv;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {15'd0, bus.gnt, bus.m_tx_ready, bus.spi_cs_n, bus.eng_tx_dv,
                bus.eng_tx_byte, bus.rx_dv, bus.timeout_err};
    endfunction

    function automatic logic [31:0] pack_exp(input logic [1:0] g, input logic rdy, input logic cs,
                                             input logic dv, input logic [7:0] b,
                                             input logic [1:0] rx, input logic to);
        return {15'd0, g, g & {2{rdy}}, cs, dv, b, rx, to};
    endfunction

    task automatic idle_inputs();
        bus.boot_done    = 1'b0;
        bus.req          = 2'b00;
        bus.m0_tx_byte   = 8'h00;
        bus.m0_tx_dv     = 1'b0;
        bus.m1_tx_byte   = 8'h00;
        bus.m1_tx_dv     = 1'b0;
        bus.eng_tx_ready = 1'b1;
        bus.eng_rx_dv    = 1'b0;
        bus.eng_rx_byte  = 8'h00;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("reset_outputs", outs(), pack_exp(2'b00, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0));
    endtask

    task automatic wait_gnt(input int bound, output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < bound; i++) begin
            if (bus.gnt != 2'b00) begin
                g = bus.gnt;
                return;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0] g;
        int         k;
        int         hi;
        logic       seen;

        idle_inputs();

        // req, m0_b, m0_dv, m1_dv, rx_in | gnt, cs_n, tx_dv, tx_b, rx_dv
        vecs[0]  = '{2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00};
        vecs[1]  = '{2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00};
        vecs[2]  = '{2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 2'b00};
        vecs[3]  = '{2'b01, 8'h03, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 8'h03, 2'b00};
        vecs[4]  = '{2'b01, 8'h02, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 8'h02, 2'b00};
        vecs[5]  = '{2'b01, 8'h00, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 8'h00, 2'b01};
        vecs[6]  = '{2'b01, 8'h00, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 8'h00, 2'b00};
        vecs[7]  = '{2'b01, 8'h00, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 2'b01};
        vecs[8]  = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 2'b00};
        vecs[9]  = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00};
        vecs[10] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00};
        vecs[11] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00};
        vecs[12] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00};
        vecs[13] = '{2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00};

        // Single boot-loader transaction; requester 1 strobes 8'hAB that must never launch.
        apply_reset();
        for (int i = 0; i < 14; i++) begin
            bus.req        = vecs[i].req;
            bus.m0_tx_byte = vecs[i].m0_b;
            bus.m0_tx_dv   = vecs[i].m0_dv;
            bus.m1_tx_byte = 8'hAB;
            bus.m1_tx_dv   = vecs[i].m1_dv;
            bus.eng_rx_dv  = vecs[i].rx_in;
            bus.eng_rx_byte = 8'h5A;
            #1;
            check($sformatf("vec%0d", i), outs(),
                  pack_exp(vecs[i].e_gnt, 1'b1, vecs[i].e_cs_n, vecs[i].e_tx_dv,
                           vecs[i].e_tx_b, vecs[i].e_rx_dv, 1'b0));
            tick();
        end

        // Fixed priority: requester 0 keeps winning while both request.
        apply_reset();
        bus.req = 2'b11;
        for (int t = 0; t < 3; t++) begin
            wait_gnt(30, g);
            check("prio_gnt", g, 2'b01);
            bus.req = 2'b10;
            tick();
            bus.req = 2'b11;
        end
        bus.req = 2'b10;
        wait_gnt(30, g);
        check("prio_gnt_r1", g, 2'b10);

        // Round-robin with one-byte transactions, starting with requester 0.
        apply_reset();
        bus.boot_done = 1'b1;
        bus.req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            wait_gnt(30, g);
            check("rr_gnt", g, (t % 2 == 1) ? 2'b10 : 2'b01);
            if (g == 2'b01) bus.m0_tx_dv = 1'b1;
            else            bus.m1_tx_dv = 1'b1;
            #1;
            check("rr_launch", bus.eng_tx_dv, 1'b1);
            tick();
            bus.m0_tx_dv = 1'b0;
            bus.m1_tx_dv = 1'b0;
            bus.req = 2'b11 & ~g;
            tick();
            bus.req = 2'b11;
            hi = 0;
            while (bus.spi_cs_n && hi < 40) begin
                hi++;
                tick();
            end
            check("rr_cs_high_min", (hi >= 4 && hi < 40) ? 1 : 0, 1);
        end

        // Timeout: owner 1 stalls after one byte; pulse lands 16 edges after the launch edge.
        apply_reset();
        bus.req = 2'b10;
        wait_gnt(30, g);
        check("to_gnt", g, 2'b10);
        bus.m1_tx_byte = 8'h9F;
        bus.m1_tx_dv   = 1'b1;
        #1;
        check("to_launch", {bus.eng_tx_dv, bus.eng_tx_byte}, {1'b1, 8'h9F});
        tick();
        bus.m1_tx_dv = 1'b0;
        k = 0;
        while (!bus.timeout_err && k < 40) begin
            tick();
            k++;
        end
        check("to_latency", k, 16);
        check("to_drain", {bus.gnt, bus.spi_cs_n}, {2'b00, 1'b0});
        tick();
        check("to_hold", {bus.timeout_err, bus.spi_cs_n}, {1'b0, 1'b1});
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.gnt != 2'b00) seen = 1'b1;
            tick();
        end
        check("to_blocked", seen, 1'b0);
        bus.req = 2'b00;
        tick();
        bus.req = 2'b10;
        wait_gnt(30, g);
        check("to_regrant", g, 2'b10);

        // Owner drops req while the engine is busy: DRAIN still delivers rx bytes.
        apply_reset();
        bus.req = 2'b01;
        wait_gnt(30, g);
        bus.m0_tx_byte = 8'h11;
        bus.m0_tx_dv   = 1'b1;
        tick();
        bus.m0_tx_dv     = 1'b0;
        bus.eng_tx_ready = 1'b0;
        bus.req          = 2'b00;
        #1;
        check("drain_ready_mask", bus.m_tx_ready, 2'b00);
        tick();
        check("drain_state", {bus.gnt, bus.spi_cs_n}, {2'b00, 1'b0});
        bus.eng_rx_dv   = 1'b1;
        bus.eng_rx_byte = 8'hC3;
        #1;
        check("drain_rx", {bus.rx_dv, bus.rx_byte}, {2'b01, 8'hC3});
        tick();
        bus.eng_rx_dv    = 1'b0;
        bus.eng_tx_ready = 1'b1;
        tick();
        check("drain_to_hold", bus.spi_cs_n, 1'b1);

        // Launch in the same cycle as req release is suppressed.
        apply_reset();
        bus.req = 2'b01;
        wait_gnt(30, g);
        bus.req      = 2'b00;
        bus.m0_tx_dv = 1'b1;
        #1;
        check("drop_suppress", bus.eng_tx_dv, 1'b0);
        bus.m0_tx_dv = 1'b0;
        tick();

        // Asynchronous reset in OWN with a launch pending.
        bus.req = 2'b01;
        wait_gnt(30, g);
        check("rst_pre_gnt", g, 2'b01);
        bus.m0_tx_dv = 1'b1;
        #1;
        check("rst_pre_launch", bus.eng_tx_dv, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async", outs(), pack_exp(2'b00, 1'b1, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0));
        apply_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
